// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: the FSM state type,
// the supported opcodes, the ALU function codes and the EX-stage ALU
// function selector.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_DEC  = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_BR   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [5:0] OP_ALU  = 6'b100000;
    localparam logic [5:0] OP_ADDI = 6'b110000;
    localparam logic [5:0] OP_ANDI = 6'b110010;
    localparam logic [5:0] OP_ORI  = 6'b110011;
    localparam logic [5:0] OP_B    = 6'b111111;
    localparam logic [5:0] OP_BEQ  = 6'b000000;
    localparam logic [5:0] OP_BNE  = 6'b000001;
    localparam logic [5:0] OP_LW   = 6'b001111;
    localparam logic [5:0] OP_SW   = 6'b011111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    // ALU operation used while an instruction is in EX (and held after it).
    // Address arithmetic for LW/SW and ADDI all use add.
    function automatic logic [3:0] ex_alu_func(input logic [5:0] opcode,
                                               input logic [3:0] func);
        case (opcode)
            OP_ALU:  return func;
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control bus between the control unit and the datapath. The datapath
// supplies the latched instruction word and the ALU zero flag; the control
// unit returns one strobe per datapath control input.
interface control_fsm_if;
    logic [31:0] Instr;
    logic        Zero;
    logic        PC_sel;
    logic        PC_LdEn;
    logic        RF_B_sel;
    logic        RF_WrEn;
    logic        RF_WrData_sel;
    logic        ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        MEM_WrEn;
    logic        MEM_out_sel;
    logic        RF_B2_seldir;
    logic        Illegal;

    modport master (
        input  Instr, Zero,
        output PC_sel, PC_LdEn, RF_B_sel, RF_WrEn, RF_WrData_sel,
               ALU_Bin_sel, ALU_func, MEM_WrEn, MEM_out_sel,
               RF_B2_seldir, Illegal
    );

    modport slave (
        output Instr, Zero,
        input  PC_sel, PC_LdEn, RF_B_sel, RF_WrEn, RF_WrData_sel,
               ALU_Bin_sel, ALU_func, MEM_WrEn, MEM_out_sel,
               RF_B2_seldir, Illegal
    );
endinterface

// File: rtl/control_decode.sv
// Combinational opcode classifier. Exactly one class flag is high for any
// opcode; anything not in the supported set is reported as illegal.
module control_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_rtype,
    output logic       is_imm,
    output logic       is_branch,
    output logic       is_load,
    output logic       is_store,
    output logic       is_illegal
);

    // Map the opcode onto its instruction class
    always_comb begin
        is_rtype   = 1'b0;
        is_imm     = 1'b0;
        is_branch  = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ALU:                  is_rtype   = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI: is_imm    = 1'b1;
            OP_B, OP_BEQ, OP_BNE:    is_branch  = 1'b1;
            OP_LW:                   is_load    = 1'b1;
            OP_SW:                   is_store   = 1'b1;
            default:                 is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit: sequences each instruction through
// IF/DEC/EX/MEM/WB or IF/DEC/BR and drives every datapath control strobe
// combinationally from the state register and the latched instruction.
// Build option: ILLEGAL_TRAP_EN -- when defined, an illegal opcode traps into
// HALT (Illegal = 1 until reset); otherwise it retires as a 3-cycle NOP.
module control_fsm
    import ctrl_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    control_fsm_if.master bus
);

    state_t     state;
    logic [5:0] opcode;
    logic [3:0] func;
    logic [3:0] alu_ex;
    logic       is_rtype, is_imm, is_branch, is_load, is_store, is_illegal;
    logic       take_branch;
    logic       unused_instr;

    assign opcode       = bus.Instr[31:26];
    assign func         = bus.Instr[3:0];
    assign unused_instr = ^bus.Instr[25:4];
    assign alu_ex       = ex_alu_func(opcode, func);

    control_decode u_decode (
        .opcode     (opcode),
        .is_rtype   (is_rtype),
        .is_imm     (is_imm),
        .is_branch  (is_branch),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_illegal (is_illegal)
    );

    // Branch resolution; an illegal opcode routed through BR never redirects
    always_comb begin
        take_branch = 1'b0;
        if (!is_illegal) begin
            case (opcode)
                OP_B:    take_branch = 1'b1;
                OP_BEQ:  take_branch = bus.Zero;
                OP_BNE:  take_branch = !bus.Zero;
                default: take_branch = 1'b0;
            endcase
        end
    end

    // State register and next-state sequencing
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_IF;
        end else begin
            case (state)
                S_IF:  state <= S_DEC;
                S_DEC: begin
                    if (is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
                        state <= S_HALT;
`else
                        state <= S_BR;
`endif
                    end else if (is_branch) begin
                        state <= S_BR;
                    end else begin
                        state <= S_EX;
                    end
                end
                S_EX:  state <= (is_load || is_store) ? S_MEM : S_WB;
                S_MEM: state <= is_load ? S_WB : S_IF;
                S_WB:  state <= S_IF;
                S_BR:  state <= S_IF;
`ifdef ILLEGAL_TRAP_EN
                S_HALT: state <= S_HALT;
`endif
                default: state <= S_IF;
            endcase
        end
    end

    // Per-state control strobes; anything not set for a state stays 0
    always_comb begin
        bus.PC_sel        = 1'b0;
        bus.PC_LdEn       = 1'b0;
        bus.RF_B_sel      = 1'b0;
        bus.RF_WrEn       = 1'b0;
        bus.RF_WrData_sel = 1'b0;
        bus.ALU_Bin_sel   = 1'b0;
        bus.ALU_func      = ALU_ADD;
        bus.MEM_WrEn      = 1'b0;
        bus.MEM_out_sel   = 1'b0;
        bus.RF_B2_seldir  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        bus.Illegal       = (state == S_HALT);
`else
        bus.Illegal       = 1'b0;
`endif
        case (state)
            S_EX: begin
                bus.ALU_Bin_sel = !is_rtype;
                bus.ALU_func    = alu_ex;
            end
            S_MEM: begin
                bus.ALU_Bin_sel = !is_rtype;
                bus.ALU_func    = alu_ex;
                if (is_load) begin
                    bus.MEM_out_sel = 1'b1;
                end
                if (is_store) begin
                    bus.RF_B_sel     = 1'b1;
                    bus.RF_B2_seldir = 1'b1;
                    bus.MEM_WrEn     = 1'b1;
                    bus.PC_LdEn      = 1'b1;
                end
            end
            S_WB: begin
                bus.RF_WrEn = 1'b1;
                bus.PC_LdEn = 1'b1;
                if (is_load) begin
                    bus.RF_WrData_sel = 1'b1;
                    bus.MEM_out_sel   = 1'b1;
                end else begin
                    bus.ALU_Bin_sel = !is_rtype;
                    bus.ALU_func    = alu_ex;
                end
            end
            S_BR: begin
                bus.RF_B_sel = 1'b1;
                bus.ALU_func = ALU_SUB;
                bus.PC_LdEn  = 1'b1;
                bus.PC_sel   = take_branch;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: every instruction pushes its expected
// per-cycle control vector, starting from IF, and the vectors are popped and
// compared one per clock on the falling edge.
module tb_control_fsm;

    typedef struct packed {
        logic       pc_sel;
        logic       pc_lden;
        logic       rf_b_sel;
        logic       rf_wren;
        logic       rf_wrdata_sel;
        logic       alu_bin_sel;
        logic [3:0] alu_func;
        logic       mem_wren;
        logic       mem_out_sel;
        logic       rf_b2_seldir;
        logic       illegal;
    } outs_t;

    localparam logic [5:0] T_ALU  = 6'b100000;
    localparam logic [5:0] T_ADDI = 6'b110000;
    localparam logic [5:0] T_ANDI = 6'b110010;
    localparam logic [5:0] T_ORI  = 6'b110011;
    localparam logic [5:0] T_B    = 6'b111111;
    localparam logic [5:0] T_BEQ  = 6'b000000;
    localparam logic [5:0] T_BNE  = 6'b000001;
    localparam logic [5:0] T_LW   = 6'b001111;
    localparam logic [5:0] T_SW   = 6'b011111;
    localparam logic [5:0] T_BAD  = 6'b101010;

    logic  clk = 1'b0;
    logic  rst_n;
    outs_t exp_q[$];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    control_fsm_if bus ();

    control_fsm dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    function automatic outs_t observe();
        outs_t o;
        o.pc_sel        = bus.PC_sel;
        o.pc_lden       = bus.PC_LdEn;
        o.rf_b_sel      = bus.RF_B_sel;
        o.rf_wren       = bus.RF_WrEn;
        o.rf_wrdata_sel = bus.RF_WrData_sel;
        o.alu_bin_sel   = bus.ALU_Bin_sel;
        o.alu_func      = bus.ALU_func;
        o.mem_wren      = bus.MEM_WrEn;
        o.mem_out_sel   = bus.MEM_out_sel;
        o.rf_b2_seldir  = bus.RF_B2_seldir;
        o.illegal       = bus.Illegal;
        return o;
    endfunction

    // Expected behaviour, cycle by cycle from IF, for one instruction
    task automatic push_instr(input logic [31:0] instr, input logic zero,
                              output int exp_ld);
        logic [5:0] op;
        outs_t      z;
        outs_t      e;
        op     = instr[31:26];
        z      = '0;
        exp_ld = 1;
        exp_q.push_back(z);
        exp_q.push_back(z);
        e = z;
        case (op)
            T_ALU, T_ADDI, T_ANDI, T_ORI: begin
                e.alu_bin_sel = (op != T_ALU);
                e.alu_func    = (op == T_ALU)  ? instr[3:0] :
                                (op == T_ANDI) ? 4'b0010 :
                                (op == T_ORI)  ? 4'b0011 : 4'b0000;
                exp_q.push_back(e);
                e.rf_wren = 1'b1;
                e.pc_lden = 1'b1;
                exp_q.push_back(e);
            end
            T_LW: begin
                e.alu_bin_sel = 1'b1;
                exp_q.push_back(e);
                e.mem_out_sel = 1'b1;
                exp_q.push_back(e);
                e = z;
                e.rf_wren       = 1'b1;
                e.pc_lden       = 1'b1;
                e.rf_wrdata_sel = 1'b1;
                e.mem_out_sel   = 1'b1;
                exp_q.push_back(e);
            end
            T_SW: begin
                e.alu_bin_sel = 1'b1;
                exp_q.push_back(e);
                e.rf_b_sel     = 1'b1;
                e.rf_b2_seldir = 1'b1;
                e.mem_wren     = 1'b1;
                e.pc_lden      = 1'b1;
                exp_q.push_back(e);
            end
            T_B, T_BEQ, T_BNE: begin
                e.rf_b_sel = 1'b1;
                e.alu_func = 4'b0001;
                e.pc_lden  = 1'b1;
                e.pc_sel   = (op == T_B) || (op == T_BEQ && zero) ||
                             (op == T_BNE && !zero);
                exp_q.push_back(e);
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                exp_ld    = 0;
                e.illegal = 1'b1;
                repeat (10) exp_q.push_back(e);
`else
                e.rf_b_sel = 1'b1;
                e.alu_func = 4'b0001;
                e.pc_lden  = 1'b1;
                exp_q.push_back(e);
`endif
            end
        endcase
    endtask

    // Pop one expected vector per clock and compare it with the DUT
    task automatic drain(input string name, output int ld_count);
        outs_t e;
        outs_t o;
        int    cyc;
        ld_count = 0;
        cyc      = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = observe();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, o, e);
            end
            total++;
            if (o.rf_wren && o.mem_wren) begin
                bad++;
                $display("FAIL %s cycle %0d write overlap: got RF_WrEn=1 MEM_WrEn=1 expected not both",
                         name, cyc);
            end
            if (o.pc_lden === 1'b1) ld_count++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input string name, input logic [31:0] instr,
                             input logic zero);
        int exp_ld;
        int ld;
        bus.Instr = instr;
        bus.Zero  = zero;
        push_instr(instr, zero, exp_ld);
        drain(name, ld);
        total++;
        if (ld !== exp_ld) begin
            bad++;
            $display("FAIL %s PC_LdEn pulses: got %0d expected %0d", name, ld, exp_ld);
        end
    endtask

    task automatic test_reset();
        outs_t o;
        rst_n     = 1'b0;
        bus.Instr = 32'h0;
        bus.Zero  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = observe();
        total++;
        if (o !== '0) begin
            bad++;
            $display("FAIL reset_state: got %h expected 0", o);
        end
        // Start an LW and abort it while it sits in MEM
        bus.Instr = {T_LW, 26'h0123456};
        rst_n     = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.MEM_out_sel !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_lw in MEM: got MEM_out_sel=%b expected 1", bus.MEM_out_sel);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            o = observe();
            total++;
            if (o !== '0) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: got %h expected 0", i, o);
            end
        end
        rst_n = 1'b1;
        run_instr("lw_after_reset", {T_LW, 26'h0123456}, 1'b0);
    endtask

    task automatic test_alu();
        run_instr("alu_f3", 32'h8000_0003, 1'b0);
        run_instr("alu_fa", 32'h8012_340A, 1'b1);
    endtask

    task automatic test_imm();
        run_instr("addi", {T_ADDI, 26'h155_5555}, 1'b0);
        run_instr("andi", {T_ANDI, 26'h0AA_AAAA}, 1'b0);
        run_instr("ori",  {T_ORI,  26'h000_000F}, 1'b1);
    endtask

    task automatic test_mem();
        run_instr("lw", {T_LW, 26'h3FF_FFFF}, 1'b0);
        run_instr("sw", {T_SW, 26'h000_1234}, 1'b1);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", {T_BEQ, 26'h000_0040}, 1'b1);
        run_instr("bne_z1", {T_BNE, 26'h000_0040}, 1'b1);
        run_instr("beq_z0", {T_BEQ, 26'h000_0040}, 1'b0);
        run_instr("bne_z0", {T_BNE, 26'h000_0040}, 1'b0);
        run_instr("b",      {T_B,   26'h000_0008}, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [9];
        ops = '{T_ALU, T_ADDI, T_ANDI, T_ORI, T_B, T_BEQ, T_BNE, T_LW, T_SW};
        for (int i = 0; i < 20; i++) begin
            run_instr("b2b", {ops[$urandom_range(0, 8)], 26'($urandom)},
                      1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_illegal();
        run_instr("illegal", {T_BAD, 26'h000_0000}, 1'b1);
`ifdef ILLEGAL_TRAP_EN
        total++;
        if (bus.Illegal !== 1'b1) begin
            bad++;
            $display("FAIL illegal_sticky: got %b expected 1", bus.Illegal);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (bus.Illegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_clear: got %b expected 0", bus.Illegal);
        end
`endif
        run_instr("alu_after_illegal", 32'h8000_0002, 1'b0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_imm();
        test_mem();
        test_branch();
        test_back_to_back();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
